// File: rtl/serial_frame_rx.sv
// Asynchronous serial frame receiver: start bit, LSB-first data, optional parity,
// one stop bit. Mid-bit sampling from a per-bit cycle counter; all outputs registered.
module serial_frame_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          ODD_BIT  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
    localparam logic          PAR_ON   = (PARITY_EN != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_next_s;
    logic [BW-1:0]          bit_cnt_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   par_bad_r;
    logic                   pend_ok_r;
    logic                   pend_perr_r;
    logic                   pend_ferr_r;
    logic                   full_s;
    logic                   half_s;
    logic                   shift_en_s;
    logic                   par_smp_s;
    logic                   stop_smp_s;

    // Nonzero when payload parity, configured sense and received parity bit disagree.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d, input logic b);
        return (^d) ^ ODD_BIT ^ b;
    endfunction

    // Next-state, counter and sample-strobe decode.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r + CW'(1);
        full_s       = (cnt_r == CNT_FULL);
        half_s       = (cnt_r == CNT_HALF);
        shift_en_s   = 1'b0;
        par_smp_s    = 1'b0;
        stop_smp_s   = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_next_s = {CW{1'b0}};
                if (!rx_in) state_next_s = START;
                else        state_next_s = IDLE;
            end
            START: begin
                if (half_s) begin
                    cnt_next_s   = {CW{1'b0}};
                    state_next_s = rx_in ? IDLE : DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (full_s) begin
                    cnt_next_s = {CW{1'b0}};
                    shift_en_s = 1'b1;
                    if (bit_cnt_r == BIT_LAST) state_next_s = PAR_ON ? PARITY : STOP;
                    else                       state_next_s = DATA;
                end else begin
                    state_next_s = DATA;
                end
            end
            PARITY: begin
                if (full_s) begin
                    cnt_next_s   = {CW{1'b0}};
                    par_smp_s    = 1'b1;
                    state_next_s = STOP;
                end else begin
                    state_next_s = PARITY;
                end
            end
            STOP: begin
                if (full_s) begin
                    cnt_next_s   = {CW{1'b0}};
                    stop_smp_s   = 1'b1;
                    state_next_s = rx_in ? IDLE : WAIT_HIGH;
                end else begin
                    state_next_s = STOP;
                end
            end
            WAIT_HIGH: begin
                cnt_next_s = {CW{1'b0}};
                if (rx_in) state_next_s = IDLE;
                else       state_next_s = WAIT_HIGH;
            end
            default: begin
                cnt_next_s   = {CW{1'b0}};
                state_next_s = IDLE;
            end
        endcase
    end

    // State, bit counter, shift register and parity capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            bit_cnt_r <= {BW{1'b0}};
            shift_r   <= {DATA_BITS{1'b0}};
            par_bad_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            if (state_r == START) begin
                bit_cnt_r <= {BW{1'b0}};
                par_bad_r <= 1'b0;
            end else begin
                if (shift_en_s) bit_cnt_r <= bit_cnt_r + BW'(1);
                if (par_smp_s)  par_bad_r <= parity_mismatch(shift_r, rx_in);
            end
            if (shift_en_s) shift_r <= {rx_in, shift_r[DATA_BITS-1:1]};
        end
    end

    // Stop-sample result is staged one cycle, so the pulses land one edge after the stop sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_ok_r   <= 1'b0;
            pend_perr_r <= 1'b0;
            pend_ferr_r <= 1'b0;
            data_out    <= {DATA_BITS{1'b0}};
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            pend_ok_r   <= stop_smp_s & rx_in;
            pend_perr_r <= stop_smp_s & rx_in & par_bad_r & PAR_ON;
            pend_ferr_r <= stop_smp_s & ~rx_in;
            data_valid  <= pend_ok_r;
            parity_err  <= pend_perr_r;
            frame_err   <= pend_ferr_r;
            busy        <= (state_r != IDLE);
            if (pend_ok_r) data_out <= shift_r;
        end
    end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal values are even and >= 4.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY_EN, default 1: 1 = frame carries a parity bit after the data bits.
REQ-004 Parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
REQ-005 clk  input  1  clock; all state changes on posedge clk.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 rx_in  input  1  serial line, already registered by the upstream synchronizing D flip-flop stage; idle level 1.
REQ-008 data_out  output  DATA_BITS  last accepted frame payload, LSB received first.
REQ-009 data_valid  output  1  one-cycle pulse: data_out updated with a new frame.
REQ-010 parity_err  output  1  one-cycle pulse coincident with data_valid when the received parity mismatches.
REQ-011 frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The block SHALL implement the states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH; all outputs SHALL be registered.
REQ-014 Let H = CLKS_PER_BIT/2 and C = CLKS_PER_BIT. Edge 0 is the posedge at which IDLE sees rx_in = 0; at that edge the state SHALL become START and the cycle counter SHALL be cleared.
REQ-015 START SHALL sample rx_in at edge H: if the sample is 0, go to DATA; if it is 1, treat it as a glitch and return to IDLE without raising any output pulse.
REQ-016 DATA SHALL sample data bit k at edge H + (k+1)*C, for k = 0..DATA_BITS-1, shifting each sample in LSB first.
REQ-017 After the last data bit, the state SHALL go to PARITY when PARITY_EN = 1, otherwise to STOP.
REQ-018 PARITY SHALL sample at the next C boundary. The computed parity SHALL be the XOR of the data bits, XORed with PARITY_ODD, XORed with the sampled bit; parity mismatch is a nonzero result.
REQ-019 STOP SHALL sample at the next C boundary, at edge S = H + (DATA_BITS + PARITY_EN + 1)*C.
REQ-020 Stop sample = 1: at edge S+1, data_out SHALL take the shifted payload and data_valid SHALL pulse for exactly one cycle. parity_err SHALL pulse in the same cycle when there is a mismatch. The state SHALL return to IDLE.
REQ-021 Stop sample = 0: frame_err SHALL pulse for one cycle at edge S+1; data_out SHALL be unchanged, data_valid SHALL stay 0 and parity_err SHALL stay 0. The state SHALL go to WAIT_HIGH.
REQ-022 WAIT_HIGH SHALL remain until rx_in = 1 is sampled, then go to IDLE; a 0 in WAIT_HIGH SHALL NOT start a frame.
REQ-023 In IDLE, a new frame SHALL be accepted with rx_in = 0 on the first cycle after returning from STOP; back-to-back frames need no gap beyond one stop bit.
REQ-024 rx_in transitions between sample edges SHALL be ignored; only the listed sample edges affect data, parity or stop results.
REQ-025 The cycle counter SHALL be wide enough for C-1 and SHALL wrap to 0 at each sample edge.
REQ-026 busy SHALL be 1 from edge 0+1 up to and including the cycle before IDLE is re-entered.

Reset
REQ-027 With reset = 1 at a posedge, the block SHALL force: state IDLE, counters 0, shift register 0, data_out 0, data_valid 0, parity_err 0, frame_err 0, busy 0.
REQ-028 Reset SHALL take priority over all other events, including a stop-sample edge.
REQ-029 Reset mid-frame SHALL abandon the frame with no data_valid or error pulse; the first frame after reset release SHALL be received normally.

Verification
REQ-030 Defaults, frame 0x A5 with even parity bit 0 and stop 1 -> data_valid pulses 1 cycle at edge 169, data_out = 0xA5, parity_err = 0.
REQ-031 Defaults, frame 0x A5 with parity bit 1 -> data_valid and parity_err both pulse at edge 169, data_out = 0xA5.
REQ-032 Defaults, frame 0x3C with stop bit 0 held low for 3 bit times -> frame_err pulses at edge 169, data_out keeps its prior value, busy stays 1 until rx_in returns high.
REQ-033 rx_in low for 4 cycles then high in IDLE -> START then IDLE, no pulses, busy high for ~8 cycles only.
REQ-034 PARITY_EN = 0, two back-to-back frames 0x01 then 0xFE -> two data_valid pulses exactly 160 cycles apart, with correct data each time.
REQ-035 Reset asserted at edge 60 of a frame, then a valid frame 0x5A -> no pulse for the aborted frame; one data_valid with data_out = 0x5A.
